// File: rtl/prog_sequencer.sv
// Instruction fetch/decode sequencer: 12-bit PC into an async ROM, latched instruction,
// EXEC-cycle control decode for the ALU/accumulator datapath, and two-byte jumps conditioned on the flags.
module prog_sequencer #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [2:0]  PASS_SLCT = 3'b010
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [11:0] LVAL,
  input  logic [7:0]  PROG_BYTE,
  input  logic        CRRY,
  input  logic        ZRO,
  output logic [11:0] PC,
  output logic [7:0]  INSTR,
  output logic [1:0]  STATE,
  output logic        EA,
  output logic        EB,
  output logic        EC,
  output logic [2:0]  SLCT,
  output logic [3:0]  D0
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_IMM   = 2'd2;

  logic [1:0]  r_state;
  logic [11:0] r_pc;
  logic [7:0]  r_instr;
  logic [1:0]  w_state_nxt;
  logic [11:0] w_pc_nxt;
  logic [7:0]  w_instr_nxt;
  logic [3:0]  w_op;
  logic        w_taken;
  logic        w_is_jump;

  assign w_op      = r_instr[7:4];
  assign w_is_jump = (w_op == 4'h3) || (w_op == 4'h4) || (w_op == 4'h5);

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      4'h3:    w_taken = CRRY;
      4'h4:    w_taken = ZRO;
      4'h5:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // LOAD overrides the EN hold and aborts whatever instruction is in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    if (LOAD) begin
      w_state_nxt = S_FETCH;
      w_pc_nxt    = LVAL;
      w_instr_nxt = 8'h00;
    end else if (EN) begin
      case (r_state)
        S_FETCH: begin
          w_instr_nxt = PROG_BYTE;
          w_pc_nxt    = r_pc + 12'd1;
          w_state_nxt = S_EXEC;
        end
        S_EXEC:  w_state_nxt = w_is_jump ? S_IMM : S_FETCH;
        S_IMM: begin
          w_pc_nxt    = w_taken ? {r_instr[3:0], PROG_BYTE} : (r_pc + 12'd1);
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    EA   = 1'b0;
    EB   = 1'b0;
    EC   = 1'b0;
    SLCT = 3'b000;
    D0   = 4'h0;
    if (EN && (r_state == S_EXEC)) begin
      if (w_op[3]) begin
        EA   = 1'b1;
        EB   = 1'b1;
        SLCT = w_op[2:0];
        D0   = r_instr[3:0];
      end else if (w_op == 4'h1) begin
        EA   = 1'b1;
        EB   = 1'b1;
        SLCT = PASS_SLCT;
        D0   = r_instr[3:0];
      end else if (w_op == 4'h2) begin
        EC   = 1'b1;
      end
    end
  end

  assign PC    = r_pc;
  assign INSTR = r_instr;
  assign STATE = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer against a cycle-level reference of the instruction rules.
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, load, crry, zro;
  logic [11:0] lval;
  logic [7:0]  prog_byte;
  logic [11:0] pc;
  logic [7:0]  instr;
  logic [1:0]  state;
  logic        ea, eb, ec;
  logic [2:0]  slct;
  logic [3:0]  d0;

  logic [7:0]  rom [4096];
  int          n_chk = 0;
  int          n_pass = 0;

  // Reference: where we are in the current instruction (0 fetch, 1 execute, 2 address byte).
  logic [11:0] m_pc;
  logic [7:0]  m_instr;
  int          m_step;

  always #5 clk = ~clk;
  assign prog_byte = rom[pc];

  prog_sequencer dut (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .LVAL(lval), .PROG_BYTE(prog_byte),
    .CRRY(crry), .ZRO(zro), .PC(pc), .INSTR(instr), .STATE(state),
    .EA(ea), .EB(eb), .EC(ec), .SLCT(slct), .D0(d0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Expected {EA,EB,EC,SLCT,D0} for the current reference position.
  function automatic logic [9:0] exp_ctrl(input logic e, input int step, input logic [7:0] ins);
    logic [3:0] op;
    op = ins[7:4];
    exp_ctrl = 10'd0;
    if (e && step == 1) begin
      if (op >= 4'h8)      exp_ctrl = {1'b1, 1'b1, 1'b0, op[2:0], ins[3:0]};
      else if (op == 4'h1) exp_ctrl = {1'b1, 1'b1, 1'b0, 3'b010, ins[3:0]};
      else if (op == 4'h2) exp_ctrl = {1'b0, 1'b0, 1'b1, 3'b000, 4'h0};
    end
  endfunction

  task automatic model_edge();
    logic [3:0] op;
    logic       take;
    op = m_instr[7:4];
    if (rst) begin
      m_pc = 12'h000; m_instr = 8'h00; m_step = 0;
    end else if (load) begin
      m_pc = lval; m_instr = 8'h00; m_step = 0;
    end else if (en) begin
      if (m_step == 0) begin
        m_instr = rom[m_pc];
        m_pc    = m_pc + 12'd1;
        m_step  = 1;
      end else if (m_step == 1) begin
        m_step = (op >= 4'h3 && op <= 4'h5) ? 2 : 0;
      end else begin
        take   = (op == 4'h5) || (op == 4'h3 && crry) || (op == 4'h4 && zro);
        m_pc   = take ? {m_instr[3:0], rom[m_pc]} : m_pc + 12'd1;
        m_step = 0;
      end
    end
  endtask

  // One clock: inputs applied at the falling edge, controls checked before the rising edge,
  // registered state checked at the next falling edge.
  task automatic cyc(input logic r, input logic l, input logic [11:0] lv, input logic e);
    rst = r; load = l; lval = lv; en = e;
    #1;
    check("ctrl", {6'd0, ea, eb, ec, slct, d0}, {6'd0, exp_ctrl(en, m_step, m_instr)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pc", {4'd0, pc}, {4'd0, m_pc});
    check("instr", {8'd0, instr}, {8'd0, m_instr});
    check("state", {14'd0, state}, m_step[15:0]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 12'h000, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rst = 1'b1; load = 1'b0; lval = 12'h000; en = 1'b1; crry = 1'b0; zro = 1'b0;
    m_pc = 12'h000; m_instr = 8'h00; m_step = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset and first fetch.
    rom[0] = 8'h1A; rom[1] = 8'h20;
    cyc(1'b1, 1'b0, 12'h000, 1'b1);
    check("rst_pc", {4'd0, pc}, 16'h000);
    check("rst_ctrl", {6'd0, ea, eb, ec, slct, d0}, 16'h000);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("lit_ctrl", {6'd0, ea, eb, ec, slct, d0}, {6'd0, 10'b1_1_0_010_1010});
    run(3);
    check("litout_pc", {4'd0, pc}, 16'h002);

    // Pause during LIT execute.
    cyc(1'b1, 1'b0, 12'h000, 1'b1);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 12'h000, 1'b0);
    check("pause_state", {14'd0, state}, 16'd1);
    run(2);

    // ALU op.
    rom[0] = 8'hB5;
    cyc(1'b1, 1'b0, 12'h000, 1'b1);
    cyc(1'b0, 1'b0, 12'h000, 1'b1);
    check("alu_ctrl", {6'd0, ea, eb, ec, slct, d0}, {6'd0, 10'b1_1_0_011_0101});
    run(1);

    // JMP, JZ not taken, JC taken.
    rom[0] = 8'h53; rom[1] = 8'h7C;
    cyc(1'b1, 1'b0, 12'h000, 1'b1); run(3);
    check("jmp_pc", {4'd0, pc}, 16'h37C);
    rom[0] = 8'h49; zro = 1'b0;
    cyc(1'b1, 1'b0, 12'h000, 1'b1); run(3);
    check("jz_pc", {4'd0, pc}, 16'h002);
    rom[0] = 8'h3A; rom[1] = 8'h55; crry = 1'b1;
    cyc(1'b1, 1'b0, 12'h000, 1'b1); run(3);
    check("jc_pc", {4'd0, pc}, 16'hA55);

    // PC wrap, LOAD during IMM, RST beats LOAD, LOAD while disabled.
    rom[12'hFFF] = 8'h00;
    cyc(1'b0, 1'b1, 12'hFFF, 1'b1); run(1);
    check("wrap_pc", {4'd0, pc}, 16'h000);
    rom[0] = 8'h53;
    cyc(1'b1, 1'b0, 12'h000, 1'b1); run(2);
    cyc(1'b0, 1'b1, 12'h123, 1'b1);
    check("ld_imm_pc", {4'd0, pc}, 16'h123);
    cyc(1'b1, 1'b1, 12'hABC, 1'b1);
    check("rst_ld_pc", {4'd0, pc}, 16'h000);
    cyc(1'b0, 1'b1, 12'h456, 1'b0);
    check("ld_dis_pc", {4'd0, pc}, 16'h456);

    // Random programs and control traffic.
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      crry = 1'($urandom);
      zro  = 1'($urandom);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
          12'($urandom), ($urandom_range(0, 99) < 80));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
